// File: rtl/logic_unit_iter_if.sv
// Bus interface for logic_unit_iter: request (start/op/a/b) and response
// (busy/done/result/zero and, with LOGIC_UNIT_PARITY_EN, parity).
// Configuration macro: LOGIC_UNIT_PARITY_EN adds the parity signal.
`timescale 1ns/1ps

interface logic_unit_iter_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             zero;
`ifdef LOGIC_UNIT_PARITY_EN
    logic             parity;

    modport slave  (input  start, op, a, b,
                    output busy, done, result, zero, parity);
    modport master (output start, op, a, b,
                    input  busy, done, result, zero, parity);
`else
    modport slave  (input  start, op, a, b,
                    output busy, done, result, zero);
    modport master (output start, op, a, b,
                    input  busy, done, result, zero);
`endif
endinterface

// File: rtl/logic_unit_iter.sv
// logic_unit_iter: multi-cycle bitwise logic unit. Latches two WIDTH-bit
// operands and an opcode on start, evaluates SLICE bits per clock (LSB slice
// first) and publishes a registered result with a zero flag.
// Configuration macro: LOGIC_UNIT_PARITY_EN adds a registered parity flag.
`timescale 1ns/1ps

module logic_unit_iter #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8
) (
    input  logic            clk,
    input  logic            reset,
    logic_unit_iter_if.slave bus
);
    localparam int BEATS = WIDTH / SLICE;
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(BEATS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // One slice of the selected bitwise function.
    function automatic logic [SLICE-1:0] eval_slice(
        input logic [2:0]       op,
        input logic [SLICE-1:0] sa,
        input logic [SLICE-1:0] sb
    );
        logic [SLICE-1:0] y;
        case (op)
            3'b000:  y = sa & sb;
            3'b001:  y = sa | sb;
            3'b010:  y = sa ^ sb;
            3'b011:  y = ~(sa & sb);
            3'b100:  y = ~(sa | sb);
            3'b101:  y = ~(sa ^ sb);
            3'b110:  y = sa & ~sb;
            3'b111:  y = sa;
            default: y = sa;
        endcase
        return y;
    endfunction

`ifdef LOGIC_UNIT_PARITY_EN
    // Even-parity helper: XOR-reduction of a full result word.
    function automatic logic parity_of(input logic [WIDTH-1:0] v);
        return ^v;
    endfunction
`endif

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_work;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;
    logic             r_busy;
    logic             r_done;
`ifdef LOGIC_UNIT_PARITY_EN
    logic             r_parity;
`endif

    // Operands are shifted right each beat, so the current slice always sits
    // in the low SLICE bits; finished slices enter the work word from the top
    // and reach their final positions after BEATS beats.
    logic [SLICE-1:0] w_beat;
    logic [WIDTH-1:0] w_next_work;
    logic             w_last;

    assign w_beat      = eval_slice(r_op, r_a[SLICE-1:0], r_b[SLICE-1:0]);
    assign w_next_work = (r_work >> SLICE) | (WIDTH'(w_beat) << (WIDTH - SLICE));
    assign w_last      = (r_cnt == LAST_CNT);

    // Control FSM and datapath registers; all outputs are registered here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= {CW{1'b0}};
            r_op     <= 3'b000;
            r_a      <= {WIDTH{1'b0}};
            r_b      <= {WIDTH{1'b0}};
            r_work   <= {WIDTH{1'b0}};
            r_result <= {WIDTH{1'b0}};
            r_zero   <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
`ifdef LOGIC_UNIT_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE, ST_DONE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_op    <= bus.op;
                        r_a     <= bus.a;
                        r_b     <= bus.b;
                        r_cnt   <= {CW{1'b0}};
                        r_busy  <= 1'b1;
                        r_state <= ST_RUN;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    r_work <= w_next_work;
                    r_a    <= r_a >> SLICE;
                    r_b    <= r_b >> SLICE;
                    if (w_last) begin
                        r_cnt    <= {CW{1'b0}};
                        r_result <= w_next_work;
                        r_zero   <= (w_next_work == {WIDTH{1'b0}});
`ifdef LOGIC_UNIT_PARITY_EN
                        r_parity <= parity_of(w_next_work);
`endif
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= ST_DONE;
                    end else begin
                        r_cnt    <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_cnt   <= {CW{1'b0}};
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.result = r_result;
    assign bus.zero   = r_zero;
`ifdef LOGIC_UNIT_PARITY_EN
    assign bus.parity = r_parity;
`endif

endmodule

// File: tb/tb_logic_unit_iter.sv
// Directed, table-driven bench for logic_unit_iter. Three instances share the
// clock and reset: SLICE=8 (main), SLICE=32 and SLICE=1.
`timescale 1ns/1ps

module tb_logic_unit_iter;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic_unit_iter_if #(.WIDTH(32)) if8 ();
    logic_unit_iter_if #(.WIDTH(32)) if32 ();
    logic_unit_iter_if #(.WIDTH(32)) if1 ();

    logic_unit_iter #(.WIDTH(32), .SLICE(8))  dut8  (.clk(clk), .reset(reset), .bus(if8));
    logic_unit_iter #(.WIDTH(32), .SLICE(32)) dut32 (.clk(clk), .reset(reset), .bus(if32));
    logic_unit_iter #(.WIDTH(32), .SLICE(1))  dut1  (.clk(clk), .reset(reset), .bus(if1));

    int n_checks = 0;
    int n_pass   = 0;
    int overlap  = 0;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        zero;
        logic        par;
    } vec_t;

    vec_t vecs[12];

    // Count any cycle in which busy and done are seen together.
    always @(negedge clk) begin
        if ((if8.busy && if8.done) || (if32.busy && if32.done) || (if1.busy && if1.done))
            overlap++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic drive(input int s, input logic st, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        case (s)
            0: begin if8.start = st;  if8.op = op;  if8.a = a;  if8.b = b;  end
            1: begin if32.start = st; if32.op = op; if32.a = a; if32.b = b; end
            default: begin if1.start = st; if1.op = op; if1.a = a; if1.b = b; end
        endcase
    endtask

    function automatic logic dn(input int s);
        case (s)
            0: return if8.done;
            1: return if32.done;
            default: return if1.done;
        endcase
    endfunction

    function automatic logic bz(input int s);
        case (s)
            0: return if8.busy;
            1: return if32.busy;
            default: return if1.busy;
        endcase
    endfunction

    function automatic logic [31:0] rs(input int s);
        case (s)
            0: return if8.result;
            1: return if32.result;
            default: return if1.result;
        endcase
    endfunction

    function automatic logic zr(input int s);
        case (s)
            0: return if8.zero;
            1: return if32.zero;
            default: return if1.zero;
        endcase
    endfunction

    // Start one operation and wait (bounded) for done. lat counts edges from
    // the accept edge up to and including the edge that raised done.
    task automatic run_op(input int s, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, output int lat, output int bcnt);
        drive(s, 1'b1, op, a, b);
        tick();
        drive(s, 1'b0, op, a, b);
        lat  = 1;
        bcnt = 0;
        while (!dn(s) && lat < 100) begin
            if (bz(s)) bcnt++;
            tick();
            lat++;
        end
    endtask

    initial begin
        int lat, bcnt, dcount, t1, t2, bad;
        logic [31:0] got;

        vecs[0]  = '{3'b010, 32'h55555555, 32'hAAAAAAAA, 32'hFFFFFFFF, 1'b0, 1'b0};
        vecs[1]  = '{3'b101, 32'h55555555, 32'hAAAAAAAA, 32'h00000000, 1'b1, 1'b0};
        vecs[2]  = '{3'b010, 32'hAAAAAAAA, 32'hAAAAAAAA, 32'h00000000, 1'b1, 1'b0};
        vecs[3]  = '{3'b000, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0};
        vecs[4]  = '{3'b001, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, 1'b0};
        vecs[5]  = '{3'b010, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 1'b0, 1'b0};
        vecs[6]  = '{3'b011, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FFF0FFF, 1'b0, 1'b0};
        vecs[7]  = '{3'b100, 32'hF0F0F0F0, 32'hFF00FF00, 32'h000F000F, 1'b0, 1'b0};
        vecs[8]  = '{3'b101, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF00FF00F, 1'b0, 1'b0};
        vecs[9]  = '{3'b110, 32'hF0F0F0F0, 32'hFF00FF00, 32'h00F000F0, 1'b0, 1'b0};
        vecs[10] = '{3'b111, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF0F0F0F0, 1'b0, 1'b0};
        vecs[11] = '{3'b001, 32'h00000001, 32'h00000000, 32'h00000001, 1'b0, 1'b1};

        reset = 1'b1;
        for (int s = 0; s < 3; s++) drive(s, 1'b0, 3'b000, 32'h0, 32'h0);
        tick();
        tick();
        check("rst_busy",   32'(if8.busy),   32'h0);
        check("rst_done",   32'(if8.done),   32'h0);
        check("rst_result", if8.result,      32'h0);
        check("rst_zero",   32'(if8.zero),   32'h0);
        reset = 1'b0;
        tick();

        // Table-driven sweep on the SLICE=8 instance.
        for (int i = 0; i < 12; i++) begin
            run_op(0, vecs[i].op, vecs[i].a, vecs[i].b, lat, bcnt);
            check($sformatf("v%0d_latency", i), 32'(lat),  32'd5);
            check($sformatf("v%0d_busy", i),    32'(bcnt), 32'd4);
            check($sformatf("v%0d_result", i),  if8.result, vecs[i].res);
            check($sformatf("v%0d_zero", i),    32'(if8.zero), 32'(vecs[i].zero));
`ifdef LOGIC_UNIT_PARITY_EN
            check($sformatf("v%0d_parity", i),  32'(if8.parity), 32'(vecs[i].par));
`endif
            tick();
            check($sformatf("v%0d_done_drop", i), 32'(if8.done), 32'h0);
        end

        // Operand changes and a stray start while running must not matter.
        drive(0, 1'b1, 3'b000, 32'hFFFF0000, 32'h0F0F0F0F);
        tick();
        drive(0, 1'b0, 3'b001, 32'h0, 32'h0);
        dcount = 0;
        got    = 32'h0;
        for (int i = 0; i < 12; i++) begin
            if8.start = (i == 1);
            tick();
            if (if8.done) begin
                dcount++;
                got = if8.result;
            end
        end
        if8.start = 1'b0;
        check("run_ignore_done_count", 32'(dcount), 32'd1);
        check("run_latched_result",    got,         32'h0F0F0000);

        // Start held high: second op accepted in the DONE cycle.
        drive(0, 1'b1, 3'b010, 32'h55555555, 32'hAAAAAAAA);
        tick();
        drive(0, 1'b1, 3'b000, 32'hFFFFFFFF, 32'h0000FFFF);
        t1 = -1; t2 = -1; dcount = 0; bad = 0; got = 32'h0;
        for (int i = 1; i <= 20 && dcount < 2; i++) begin
            tick();
            if (if8.done) begin
                dcount++;
                if (dcount == 1) begin
                    t1  = i;
                    got = if8.result;
                end else begin
                    t2 = i;
                    if8.start = 1'b0;
                end
            end else if (dcount == 1 && if8.result !== 32'hFFFFFFFF) begin
                bad++;
            end
        end
        if8.start = 1'b0;
        check("b2b_first_done",  32'(t1),     32'd4);
        check("b2b_gap",         32'(t2 - t1), 32'd5);
        check("b2b_first_value", got,         32'hFFFFFFFF);
        check("b2b_hold",        32'(bad),    32'd0);
        check("b2b_second",      if8.result,  32'h0000FFFF);
        tick();
        check("b2b_idle_busy",   32'(if8.busy), 32'h0);

        // Reset during the second beat aborts the operation.
        drive(0, 1'b1, 3'b111, 32'h12345678, 32'h0);
        tick();
        drive(0, 1'b0, 3'b111, 32'h12345678, 32'h0);
        tick();
        reset = 1'b1;
        #1;
        check("abort_busy",   32'(if8.busy), 32'h0);
        check("abort_done",   32'(if8.done), 32'h0);
        check("abort_result", if8.result,    32'h0);
        check("abort_zero",   32'(if8.zero), 32'h0);
        #2;
        reset = 1'b0;
        dcount = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (if8.done) dcount++;
        end
        check("abort_no_done", 32'(dcount), 32'd0);
        run_op(0, 3'b010, 32'h0F0F0F0F, 32'h00FF00FF, lat, bcnt);
        check("after_abort_latency", 32'(lat), 32'd5);
        check("after_abort_result",  if8.result, 32'h0FF00FF0);
        tick();

        // SLICE=32: single beat.
        run_op(1, 3'b010, 32'h55555555, 32'hAAAAAAAA, lat, bcnt);
        check("s32_latency", 32'(lat),  32'd2);
        check("s32_busy",    32'(bcnt), 32'd1);
        check("s32_result",  rs(1),     32'hFFFFFFFF);
        check("s32_zero",    32'(zr(1)), 32'h0);
        tick();

        // SLICE=1: one bit per beat.
        run_op(2, 3'b100, 32'hF0F0F0F0, 32'hFF00FF00, lat, bcnt);
        check("s1_latency", 32'(lat),  32'd33);
        check("s1_busy",    32'(bcnt), 32'd32);
        check("s1_result",  rs(2),     32'h000F000F);
        tick();

        check("busy_done_overlap", 32'(overlap), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/logic_unit_iter.md
# logic_unit_iter

Parametrised, multi-cycle bitwise logic unit for the vALU datapath, the successor to the fixed 32-bit XOR slice.
- Latches two WIDTH-bit operands and an opcode on a start handshake.
- Evaluates one of eight bitwise functions SLICE bits per clock, LSB slice first.
- Presents a registered result with zero and (optionally) parity flags.
- Sits beside the adder in the ALU and is used when area matters more than single-cycle latency.

## Interface
Parameters:
- WIDTH, 32, operand/result width in bits.
- SLICE, 8, bits evaluated per beat; WIDTH must be an integer multiple of SLICE, SLICE ≥ 1.

Ports:
- clk  in  1  clock, rising-edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  request; accepted only in IDLE or DONE.
- op  in  3  function select, latched at accept.
- a  in  WIDTH  operand A, latched at accept.
- b  in  WIDTH  operand B, latched at accept.
- busy  out  1  high while in RUN.
- done  out  1  single-cycle completion pulse.
- result  out  WIDTH  last completed result, registered.
- zero  out  1  result == 0, registered with result.
- parity  out  1  XOR-reduction of result (present only with LOGIC_UNIT_PARITY_EN).

## Operation
- Op encoding:
  - 000 AND
  - 001 OR
  - 010 XOR
  - 011 NAND
  - 100 NOR
  - 101 XNOR
  - 110 A AND NOT B
  - 111 pass A
- BEATS = WIDTH/SLICE; beat counter width is clog2(BEATS), minimum 1 bit.
- States: IDLE, RUN, DONE.
  - IDLE: start=1 → latch a, b, op; counter=0; go to RUN. start=0 → stay in IDLE.
  - RUN: compute bits [cnt*SLICE +: SLICE] of the latched operands into an internal work register; cnt+1.
    - On the last beat (cnt == BEATS-1): copy the completed word into result; update zero/parity; go to DONE.
    - start is ignored in RUN.
  - DONE: done=1 for exactly this cycle.
    - start=1 → accept a new operation (same as IDLE) and go to RUN.
    - Otherwise go to IDLE.
- result, zero and parity change only at completion. They hold their value through IDLE and through the next RUN, until the next completion.
- Operands and op may change freely after accept with no effect on the operation in flight.
- SLICE == WIDTH: BEATS=1, one RUN cycle.
- Reset (asynchronous, any state, including mid-RUN):
  - State → IDLE, counter → 0, busy=0, done=0, result=0, zero=0, parity=0.
  - The aborted operation never signals done.

## Timing
- Start sampled high at edge k in IDLE/DONE:
  - busy=1 after edge k.
  - Beats are evaluated at edges k+1 … k+BEATS.
  - After edge k+BEATS: busy=0, done=1, result valid.
- Latency: BEATS+1 edges from accept to done (5 for 32/8).
- Back-to-back throughput: one operation per BEATS+1 cycles when start is held high.
- done and busy are never high together.
- No combinational path from inputs to any output.

## Configuration
- LOGIC_UNIT_PARITY_EN defined:
  - parity port exists.
  - Registered at completion as the XOR-reduce of the new result.
  - Resets to 0.
- LOGIC_UNIT_PARITY_EN undefined:
  - parity port and its register are absent.
  - All other behaviour is identical.

## Test plan
- WIDTH=32, SLICE=8, op=010, a=0x55555555, b=0xAAAAAAAA, start one cycle:
  - done pulses exactly 5 edges after accept, busy high 4 cycles.
  - result=0xFFFFFFFF, zero=0, parity=0.
- Same operands, op=101 (XNOR) → result=0x00000000, zero=1; then op=010 with a=b=0xAAAAAAAA → result=0, zero=1.
- a=0xF0F0F0F0, b=0xFF00FF00, sweep all 8 ops:
  - AND F000F000, OR FFF0FFF0, XOR 0FF00FF0, NAND 0FFF0FFF.
  - NOR 000F000F, XNOR F00FF00F, ANDN 00F000F0, pass F0F0F0F0.
- Change a/b during RUN, and pulse start during RUN → result reflects the latched operands; the second start is ignored (one done only).
- Hold start high across two operations → the second is accepted in the DONE cycle; done pulses are 5 cycles apart; result stays at the first value until the second done.
- Assert reset in the 2nd RUN beat:
  - All outputs 0 immediately, no done.
  - The next operation completes normally.
- Repeat with SLICE=32 (latency 2) and SLICE=1 (latency 33).
- With LOGIC_UNIT_PARITY_EN defined: a=0x00000001, b=0, op=001 → parity=1.
